// File: rtl/ingress_rr_arbiter.sv
// Ingress stage in front of shared_buffer: one small FIFO per input port,
// round-robin selection of one non-empty FIFO per cycle, and a registered
// write strobe / data / source tag towards the buffer's write side.
module ingress_rr_arbiter #(
  parameter int NPORTS     = 4,
  parameter int DW         = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int PW         = $clog2(NPORTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NPORTS-1:0]    in_valid,
  input  logic [NPORTS*DW-1:0] in_data,
  output logic [NPORTS-1:0]    in_ready,
  input  logic                 buf_full,
  output logic                 wr_req,
  output logic [DW-1:0]        wdata,
  output logic [PW-1:0]        wsrc
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  // FIFO storage and per-port bookkeeping
  logic [DW-1:0] mem_q    [NPORTS][FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q [NPORTS];
  logic [AW-1:0] rd_ptr_d [NPORTS];
  logic [AW-1:0] wr_ptr_q [NPORTS];
  logic [AW-1:0] wr_ptr_d [NPORTS];
  logic [CW-1:0] cnt_q    [NPORTS];
  logic [CW-1:0] cnt_d    [NPORTS];

  // Arbitration and issue state
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic              wr_req_q, wr_req_d;
  logic [DW-1:0]     wdata_q,  wdata_d;
  logic [PW-1:0]     wsrc_q,   wsrc_d;

  logic [NPORTS-1:0] req;
  logic [NPORTS-1:0] push;
  logic [NPORTS-1:0] pop;
  logic [PW-1:0]     grant;
  logic              grant_found;
  logic              grant_valid;
  int                scan_idx;

  // Ready, push and request flags straight from registered FIFO counts
  always_comb begin
    for (int i = 0; i < NPORTS; i++) begin
      in_ready[i] = ~rst & (cnt_q[i] != CW'(FIFO_DEPTH));
      push[i]     = in_valid[i] & in_ready[i];
      req[i]      = (cnt_q[i] != '0);
    end
  end

  // Round-robin scan starting at rr_ptr; grant only when the buffer has room
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned and infers a latch.
    grant       = '0;
    grant_found = 1'b0;
    scan_idx    = 0;
    for (int k = 0; k < NPORTS; k++) begin
      scan_idx = (int'(rr_ptr_q) + k) % NPORTS;
      if (!grant_found && req[scan_idx]) begin
        grant_found = 1'b1;
        grant       = PW'(scan_idx);
      end
    end
    grant_valid = grant_found & ~buf_full;
  end

  // Next-state for FIFO pointers and counts; push and pop may coincide
  always_comb begin
    for (int i = 0; i < NPORTS; i++) begin
      pop[i]      = grant_valid & (grant == PW'(i));
      rd_ptr_d[i] = rd_ptr_q[i] + AW'(pop[i]);
      wr_ptr_d[i] = wr_ptr_q[i] + AW'(push[i]);
      cnt_d[i]    = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
    end
  end

  // Next-state for the write-side outputs and the round-robin pointer
  always_comb begin
    wr_req_d = 1'b0;
    wdata_d  = wdata_q;
    wsrc_d   = wsrc_q;
    rr_ptr_d = rr_ptr_q;
    if (grant_valid) begin
      wr_req_d = 1'b1;
      wdata_d  = mem_q[grant][rd_ptr_q[grant]];
      wsrc_d   = grant;
      rr_ptr_d = (grant == PW'(NPORTS - 1)) ? '0 : grant + PW'(1);
    end
  end

  // Control state with synchronous reset; reset discards all queued words
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      for (int i = 0; i < NPORTS; i++) begin
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      rr_ptr_q <= '0;
      wr_req_q <= 1'b0;
      wdata_q  <= '0;
      wsrc_q   <= '0;
    end else begin
      for (int i = 0; i < NPORTS; i++) begin
        rd_ptr_q[i] <= rd_ptr_d[i];
        wr_ptr_q[i] <= wr_ptr_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
      rr_ptr_q <= rr_ptr_d;
      wr_req_q <= wr_req_d;
      wdata_q  <= wdata_d;
      wsrc_q   <= wsrc_d;
    end
  end

  // FIFO storage write port
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; cleared counts make
    // stale contents unreachable, and leaving it unreset keeps it RAM-mappable.
    for (int i = 0; i < NPORTS; i++) begin
      if (push[i]) begin
        mem_q[i][wr_ptr_q[i]] <= in_data[i*DW +: DW];
      end
    end
  end

  assign wr_req = wr_req_q;
  assign wdata  = wdata_q;
  assign wsrc   = wsrc_q;

endmodule

// File: tb/tb_ingress_rr_arbiter.sv
// Self-checking bench for ingress_rr_arbiter: a queue-based reference model
// predicts in_ready and the write-side outputs every cycle, and directed
// scenarios pin the model with hand-computed literal expectations.
module tb_ingress_rr_arbiter;

  localparam int NP    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int PW    = 2;

  logic               clk;
  logic               rst;
  logic [NP-1:0]      in_valid;
  logic [NP*DW-1:0]   in_data;
  logic [NP-1:0]      in_ready;
  logic               buf_full;
  logic               wr_req;
  logic [DW-1:0]      wdata;
  logic [PW-1:0]      wsrc;

  ingress_rr_arbiter #(
    .NPORTS(NP), .DW(DW), .FIFO_DEPTH(DEPTH), .PW(PW)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .buf_full(buf_full), .wr_req(wr_req),
    .wdata(wdata), .wsrc(wsrc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: per-port queues and the round-robin start point
  logic [DW-1:0] mq [NP][$];
  int            m_rr;
  logic          m_wr;
  logic [DW-1:0] m_wdata;
  logic [PW-1:0] m_wsrc;

  // Last observed DUT values, used by the directed literal checks
  logic [NP-1:0] obs_rdy;
  logic          obs_wr;
  logic [DW-1:0] obs_wdata;
  logic [PW-1:0] obs_wsrc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Apply inputs, advance the model one clock, and compare the DUT to it
  task automatic cycle(input logic r, input logic [NP-1:0] v,
                       input logic [NP*DW-1:0] d, input logic full);
    logic [NP-1:0] rdy;
    int g;
    rst = r; in_valid = v; in_data = d; buf_full = full;
    #1;
    for (int i = 0; i < NP; i++) rdy[i] = !r && (mq[i].size() != DEPTH);
    obs_rdy = in_ready;
    check("in_ready", in_ready, rdy);
    if (r) begin
      for (int i = 0; i < NP; i++) mq[i].delete();
      m_rr = 0; m_wr = 1'b0; m_wdata = '0; m_wsrc = '0;
    end else begin
      g = -1;
      for (int k = 0; k < NP; k++) begin
        int j;
        j = (m_rr + k) % NP;
        if (g < 0 && mq[j].size() > 0) g = j;
      end
      if (g >= 0 && !full) begin
        m_wr    = 1'b1;
        m_wdata = mq[g].pop_front();
        m_wsrc  = PW'(g);
        m_rr    = (g + 1) % NP;
      end else begin
        m_wr = 1'b0;
      end
      for (int i = 0; i < NP; i++)
        if (v[i] && rdy[i]) mq[i].push_back(d[i*DW +: DW]);
    end
    @(posedge clk);
    #1;
    check("wr_req", wr_req, m_wr);
    check("wdata", wdata, m_wdata);
    check("wsrc", wsrc, m_wsrc);
    obs_wr = wr_req; obs_wdata = wdata; obs_wsrc = wsrc;
  endtask

  task automatic idle(input logic full);
    cycle(1'b0, '0, '0, full);
  endtask

  function automatic logic [NP*DW-1:0] one_word(input int port, input logic [DW-1:0] w);
    logic [NP*DW-1:0] d;
    d = '0;
    d[port*DW +: DW] = w;
    return d;
  endfunction

  initial begin
    logic [NP*DW-1:0] d;
    logic [DW-1:0]    got [$];
    int               sent;
    int               issued;

    rst = 1'b1; in_valid = '0; in_data = '0; buf_full = 1'b0;
    m_rr = 0; m_wr = 1'b0; m_wdata = '0; m_wsrc = '0;
    @(posedge clk); #1;

    // 1. Reset for two cycles, then all ports ready
    cycle(1'b1, '0, '0, 1'b0);
    check("rst_in_ready", obs_rdy, 4'b0000);
    check("rst_wr_req", obs_wr, 1'b0);
    cycle(1'b1, '0, '0, 1'b0);
    check("rst_wdata", obs_wdata, 8'h00);
    idle(1'b0);
    check("post_rst_ready", obs_rdy, 4'b1111);

    // 2. Single word on port 2: issued after the second edge only
    cycle(1'b0, 4'b0100, one_word(2, 8'h0D), 1'b0);
    check("single_no_bypass", obs_wr, 1'b0);
    idle(1'b0);
    check("single_wr", obs_wr, 1'b1);
    check("single_wdata", obs_wdata, 8'h0D);
    check("single_wsrc", obs_wsrc, 2);
    idle(1'b0);
    check("single_wr_drop", obs_wr, 1'b0);
    check("single_hold", obs_wdata, 8'h0D);

    // 3. Simultaneous push on all ports from rr_ptr=0
    cycle(1'b1, '0, '0, 1'b0);
    cycle(1'b0, 4'b1111, {8'h13, 8'h12, 8'h11, 8'h10}, 1'b0);
    for (int i = 0; i < NP; i++) begin
      idle(1'b0);
      check("simul_wr", obs_wr, 1'b1);
      check("simul_wsrc", obs_wsrc, i);
      check("simul_wdata", obs_wdata, 8'h10 + i);
    end
    idle(1'b0);
    check("simul_done", obs_wr, 1'b0);

    // 4. Fairness: ports 0 and 3 always valid; rr_ptr is back at 0
    cycle(1'b0, 4'b1001, {8'hC0, 16'h0, 8'h40}, 1'b0);
    for (int n = 0; n < 10; n++) begin
      d = '0;
      d[0 +: DW]      = 8'(8'h41 + n);
      d[3*DW +: DW]   = 8'(8'hC1 + n);
      cycle(1'b0, 4'b1001, d, 1'b0);
      check("fair_wr", obs_wr, 1'b1);
      check("fair_wsrc", obs_wsrc, (n % 2 == 0) ? 0 : 3);
    end
    for (int n = 0; n < 12; n++) idle(1'b0);

    // 5. Backpressure on port 1 with words 01..06
    cycle(1'b1, '0, '0, 1'b0);
    sent = 0;
    for (int n = 0; n < 6; n++) begin
      cycle(1'b0, 4'b0010, one_word(1, 8'(sent + 1)), 1'b1);
      if (obs_rdy[1]) sent++;
      check("bp_no_issue", obs_wr, 1'b0);
    end
    check("bp_accepted", sent, 4);
    check("bp_ready_low", obs_rdy[1], 1'b0);
    got.delete();
    for (int n = 0; n < 20; n++) begin
      if (sent < 6) begin
        cycle(1'b0, 4'b0010, one_word(1, 8'(sent + 1)), 1'b0);
        if (obs_rdy[1]) sent++;
      end else begin
        idle(1'b0);
      end
      if (obs_wr) got.push_back(obs_wdata);
    end
    check("bp_count", got.size(), 6);
    for (int i = 0; i < 6; i++)
      check("bp_order", (i < got.size()) ? got[i] : 8'hFF, 8'(i + 1));

    // 6. Reset mid-stream with three words queued on port 0
    for (int n = 0; n < 3; n++) cycle(1'b0, 4'b0001, one_word(0, 8'(8'hA0 + n)), 1'b1);
    cycle(1'b1, '0, '0, 1'b0);
    check("midrst_wr", obs_wr, 1'b0);
    issued = 0;
    for (int n = 0; n < 6; n++) begin
      idle(1'b0);
      if (obs_wr) issued++;
    end
    check("midrst_no_stale", issued, 0);
    for (int n = 0; n < 5; n++) begin
      cycle(1'b0, 4'b0001, one_word(0, 8'(8'hB0 + n)), 1'b1);
      check("midrst_space", obs_rdy[0], (n < 4) ? 1'b1 : 1'b0);
    end
    cycle(1'b1, '0, '0, 1'b0);

    // Randomised traffic with occasional backpressure and resets
    for (int n = 0; n < 3000; n++) begin
      logic          r;
      logic          f;
      logic [NP-1:0] v;
      r = ($urandom_range(0, 199) == 0);
      f = ($urandom_range(0, 99) < 30);
      v = NP'($urandom);
      d = {$urandom};
      cycle(r, v, d, f);
    end
    for (int n = 0; n < 20; n++) idle(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
